// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode/state encodings, defaults and the bit-reverse helper
// used by both the master and slave interfaces.
package spi_pkg;

    // Mode bit 1 is CPOL, bit 0 is CPHA.
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } spi_state_e;

    localparam logic [7:0]  DEFAULT_FILL_BYTE = 8'hFF;
    localparam int unsigned FIFO_DEPTH        = 4;

    function automatic logic [7:0] bit_rev(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one external SPI line, followed by a single edge-detect flop.
module spi_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign q    = sync_q[SYNC_STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;

endmodule

// File: rtl/srl_fifo.sv
// Shift-register FIFO: pushes enter at slot 0, the oldest entry sits at slot count-1.
module srl_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    count_q;
    logic [AW-1:0]    rd_addr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    // A push into a full FIFO is refused even when a pop happens in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_addr = AW'(count_q - CW'(1));
    assign dout    = mem[rd_addr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (do_push && !do_pop) begin
            count_q <= count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/spi_slave_if.sv
// SPI target interface: synchronizes SCK/SS/MOSI into clk, shifts bytes between the
// serial line and RX/TX FIFOs, and exposes the same cmd/wr/rd/ack bus as the master.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  FILL_BYTE   = DEFAULT_FILL_BYTE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       cmd,
    input  logic       wr,
    input  logic       rd,
    output logic [8:0] dout,
    output logic       ack,
    output logic       rx_ovr,
    output logic       tx_udr,
    output logic       busy,
    input  logic       spi_sck,
    input  logic       spi_ss,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe
);

    logic sck_level_unused, sck_rise, sck_fall;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk(clk), .rst(rst), .d(spi_sck),
        .q(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .rst(rst), .d(spi_ss),
        .q(ss_s), .rise(ss_rise), .fall(ss_fall)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .d(spi_mosi),
        .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_state_e state_q, state_d;
    spi_mode_e  mode_q;
    logic       lsb_q;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] rx_sr_q, rx_sr_d;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic       rx_ovr_q, rx_ovr_d;
    logic       tx_udr_q, tx_udr_d;
    logic       ack_q;

    logic [7:0] tx_fifo_dout, rx_fifo_dout, rx_asm, tx_byte;
    logic       tx_empty, tx_full, rx_empty, rx_full;
    logic       tx_load, tx_pop, rx_push, rx_pop, sample, cmd_ok;

    srl_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .din(din), .push(wr), .pop(tx_pop),
        .dout(tx_fifo_dout), .empty(tx_empty), .full(tx_full)
    );
    srl_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .din(lsb_q ? bit_rev(rx_asm) : rx_asm), .push(rx_push),
        .pop(rx_pop), .dout(rx_fifo_dout), .empty(rx_empty), .full(rx_full)
    );

    // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
    assign sample  = (mode_q[1] == mode_q[0]) ? sck_rise : sck_fall;
    assign rx_asm  = {rx_sr_q[6:0], mosi_s};
    assign tx_byte = tx_empty ? FILL_BYTE : tx_fifo_dout;
    assign tx_pop  = tx_load & ~tx_empty;
    assign rx_pop  = rd & ~rx_empty;
    assign cmd_ok  = cmd & (state_q == S_IDLE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rx_sr_d  = rx_sr_q;
        tx_sr_d  = tx_sr_q;
        tx_load  = 1'b0;
        rx_push  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ss_fall) begin
                    state_d = S_ACTIVE;
                    cnt_d   = '0;
                    tx_load = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (ss_rise) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (sample) begin
                    rx_sr_d = rx_asm;
                    tx_sr_d = {tx_sr_q[6:0], 1'b0};
                    cnt_d   = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        rx_push = 1'b1;
                        tx_load = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (tx_load) begin
            tx_sr_d = lsb_q ? bit_rev(tx_byte) : tx_byte;
        end

        // Clear by cmd first so a same-cycle set wins.
        rx_ovr_d = rx_ovr_q & ~cmd_ok;
        tx_udr_d = tx_udr_q & ~cmd_ok;
        if (rx_push && rx_full) rx_ovr_d = 1'b1;
        if (tx_load && tx_empty) tx_udr_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mode_q   <= MODE0;
            lsb_q    <= 1'b0;
            cnt_q    <= '0;
            rx_sr_q  <= '0;
            tx_sr_q  <= FILL_BYTE;
            rx_ovr_q <= 1'b0;
            tx_udr_q <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rx_sr_q  <= rx_sr_d;
            tx_sr_q  <= tx_sr_d;
            rx_ovr_q <= rx_ovr_d;
            tx_udr_q <= tx_udr_d;
            ack_q    <= (wr & ~tx_full) | rd | cmd;
            if (cmd_ok) begin
                mode_q <= spi_mode_e'(din[1:0]);
                lsb_q  <= din[2];
            end
        end
    end

    assign dout        = rx_pop ? {1'b0, rx_fifo_dout} : 9'h100;
    assign ack         = ack_q;
    assign rx_ovr      = rx_ovr_q;
    assign tx_udr      = tx_udr_q;
    assign busy        = (state_q == S_ACTIVE);
    assign spi_miso    = tx_sr_q[7];
    assign spi_miso_oe = ~ss_s;

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
- SPI slave (target) interface: the counterpart of the existing SPI master interface.
- Samples external SPI_SCK, SPI_SS and SPI_MOSI into the system clock domain and shifts received bytes into an RX FIFO.
- Shifts bytes from a TX FIFO out on SPI_MISO.
- Bus side uses the same cmd/wr/rd/ack strobe interface as the master, so one wishbone wrapper can host either block.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in the SCK/SS/MOSI input synchronizers (min 2).
- FILL_BYTE, 8'hFF, byte shifted out when the TX FIFO is empty at byte load.

Ports:
- clk  in  1  system clock; one clock only.
- rst  in  1  reset; synchronous, active-high.
- din  in  8  bus data: byte to TX on wr; on cmd, [1:0]=mode {CPOL,CPHA}, [2]=endianness (0 MSB first, 1 LSB first).
- cmd  in  1  settings write strobe.
- wr  in  1  TX byte write strobe.
- rd  in  1  RX byte read strobe.
- dout  out  9  {empty, data}: {0, rx_byte} during an accepted rd, else 9'h100.
- ack  out  1  registered acknowledge.
- rx_ovr  out  1  sticky: RX byte dropped because the RX FIFO was full.
- tx_udr  out  1  sticky: FILL_BYTE sent because the TX FIFO was empty.
- busy  out  1  high while state = ACTIVE.
- spi_sck  in  1  external serial clock.
- spi_ss  in  1  slave select, active low.
- spi_mosi  in  1  serial data in.
- spi_miso  out  1  serial data out.
- spi_miso_oe  out  1  MISO tristate enable; 1 when synchronized SS is low.

Behaviour:
- Reset values:
  - Mode 0, MSB first, state IDLE, bit counter 0.
  - Both FIFOs empty.
  - TX shift register = FILL_BYTE, so spi_miso = FILL_BYTE's first bit.
  - spi_miso_oe=0, ack=0, rx_ovr=0, tx_udr=0, busy=0.
- Reset mid-transfer aborts immediately and discards the partial byte.
- Input synchronization:
  - SCK, SS and MOSI each pass SYNC_STAGES flops, then one edge-detect flop.
  - Requirement on the external master: SCK high time and low time each ≥ SYNC_STAGES+3 clk.
  - Requirement: SS-low to first SCK edge ≥ SYNC_STAGES+3 clk.
- Sample edge = rising when CPOL==CPHA (modes 0, 3); falling otherwise (modes 1, 2). The other SCK edge is ignored.
- State machine IDLE / ACTIVE:
  - IDLE → ACTIVE on synced SS falling edge. Load the TX shift register (pop TX FIFO, or FILL_BYTE with tx_udr set); bit counter = 0.
  - ACTIVE, sample edge:
    - Capture synced MOSI into the RX shift register.
    - Shift the TX register so the next bit appears on MISO.
    - Increment the bit counter.
  - ACTIVE, 8th sample (counter 7→0):
    - Push the assembled byte (endianness-ordered) to the RX FIFO; if the FIFO is full, drop the byte and set rx_ovr.
    - In the same cycle, load the next TX byte as at SS fall.
  - ACTIVE → IDLE on synced SS rising edge at any bit position. Partial RX byte discarded; a TX byte already loaded is lost (not returned to the FIFO); counter = 0.
  - SS falling and rising edges both seen while SCK is idle: counter stays 0, nothing pushed.
- MISO timing:
  - The first bit is valid ≤ SYNC_STAGES+2 clk after SS falls.
  - Each later bit changes SYNC_STAGES+2 clk after the sample edge. This serves both CPHA settings.
- Endianness: reversal is applied at TX load and at RX push. The FIFOs always hold natural byte order.
- cmd:
  - Accepted only in IDLE; ignored (but acked) in ACTIVE.
  - Clears rx_ovr and tx_udr. Sticky-set and clear in the same cycle → set wins.
- wr:
  - Pushes din into the TX FIFO if not full; a wr to a full FIFO is dropped and not acked.
  - wr and a TX pop in the same cycle on a full FIFO: the push is still refused.
- rd: pops the RX FIFO if not empty; dout is combinational during rd.
- ack <= (wr & ~tx_full) | rd | cmd, one cycle after the strobe.

Decomposition:
- spi_pkg holds: mode encodings (MODE0..MODE3), state encoding (S_IDLE, S_ACTIVE), default FILL_BYTE, bit-reverse function shared with the master.
- Sub-module spi_sync: parameterized SYNC_STAGES synchronizer plus rise/fall detect, instantiated for SCK and SS; the MOSI instance has its edge outputs unused.
- FIFOs reuse the existing srl_fifo: WIDTH 8, two instances.

Test Plan:
1. Mode 0, wr 8'hA5, 8'h3C; master sends 8'h5A, 8'hC3 in one 16-bit SS-low frame → MISO bits 10100101 00111100; two rd → dout 9'h05A, 9'h0C3; third rd → 9'h100.
2. cmd din=3'b111 (mode 3, LSB first); wr 8'h01; master sends bits 1,0,0,0,0,0,0,0 → first MISO bit 1; rd → 9'h001.
3. TX FIFO empty, master clocks 8 bits → MISO = 8'hFF, tx_udr=1; cmd → tx_udr=0, ack 1 cycle later.
4. Fill RX FIFO to full, then one more byte 8'h77 → rx_ovr=1; reading out shows the original bytes and no 8'h77.
5. SS deasserted after 5 bits → no RX push, busy=0; next frame loads the next TX byte and counter starts at 0.
6. rst asserted mid-byte in mode 1 → next cycle all outputs at reset values; cmd issued while busy=1 → acked and mode unchanged.
